data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 29 ++
 rtl/data_mem_responder_req_fifo.sv | 71 +++++++
 rtl/data_mem_responder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared CPU definitions used by the load/store queue and the data-memory responder:
// responder FSM states, default memory latency, op encoding and the queued request layout.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } memState_e;

    localparam int DEFAULT_MEM_LAT = 2;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  regTag;
        logic [31:0] addr;
        logic [31:0] data;
        logic        store;
        logic        found;
    } memReq_t;

    function automatic logic isMisaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_responder_req_fifo.sv
// Circular request queue with wrapping head/tail pointers and an occupancy count.
module req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] slots_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = slots_q[head_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (doPush) begin
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
        end
        if (doPop) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Slot contents need no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            slots_q[tail_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: queues issued loads/stores, completes them in order against a
// word-addressed memory with fixed latency, and returns one-cycle result pulses to the LSQ.
module data_mem_responder #(
    parameter int MEM_WORDS = 256,
    parameter int Q_DEPTH   = 4,
    parameter int MEM_LAT   = data_mem_responder_pkg::DEFAULT_MEM_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    input  logic [5:0]  req_reg,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        req_store,
    input  logic        req_found,
    output logic        req_ready,
    output logic        ld_valid,
    output logic [31:0] ld_pc,
    output logic [5:0]  ld_reg,
    output logic [31:0] ld_data,
    output logic        st_done,
    output logic [31:0] st_data,
    output logic [31:0] st_pc,
    output logic        addr_err
);

    import data_mem_responder_pkg::*;

    localparam int WORD_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CNT_W  = $clog2(Q_DEPTH + 1);
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    memReq_t            enqReq;
    memReq_t            headReq;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [CNT_W-1:0]   fifoCount;
    logic               reqAccept;
    logic               popReq;
    logic               popMisaligned;
    logic               popForward;
    logic               memFire;
    logic               unusedBits;

    memState_e          state_q, state_d;
    logic [2:0]         latCnt_q, latCnt_d;
    logic [31:0]        curPc_q;
    logic [5:0]         curReg_q;
    logic [31:0]        curData_q;
    logic               curStore_q;
    logic [WORD_W-1:0]  curWord_q;

    logic [31:0]        mem_q [MEM_WORDS];
    logic               ldValid_q;
    logic [31:0]        ldPc_q;
    logic [5:0]         ldReg_q;
    logic [31:0]        ldData_q;
    logic               stDone_q;
    logic [31:0]        stData_q;
    logic [31:0]        stPc_q;
    logic               addrErr_q;

    assign enqReq = '{pc: req_pc, regTag: req_reg, addr: req_addr, data: req_data,
                      store: req_store, found: req_found};
    assign req_ready  = (int'(fifoCount) < Q_DEPTH);
    assign reqAccept  = req_valid && req_ready;
    // Address bits above the memory word index alias and are deliberately ignored.
    assign unusedBits = ^{fifoFull, headReq.addr[31:WORD_W+2]};

    req_fifo #(
        .WIDTH ($bits(memReq_t)),
        .DEPTH (Q_DEPTH)
    ) u_reqFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (reqAccept),
        .pop_i   (popReq),
        .wdata_i (enqReq),
        .rdata_o (headReq),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    always_comb begin
        state_d       = state_q;
        latCnt_d      = latCnt_q;
        popReq        = 1'b0;
        popMisaligned = 1'b0;
        popForward    = 1'b0;
        memFire       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    popReq = 1'b1;
                    if (isMisaligned(headReq.addr)) begin
                        popMisaligned = 1'b1;
                    end else if (headReq.found && (headReq.store == OP_LOAD)) begin
                        popForward = 1'b1;
                        state_d    = RESPOND;
                    end else begin
                        state_d  = ACCESS;
                        latCnt_d = LAT_INIT;
                    end
                end
            end
            ACCESS: begin
                if (latCnt_q == 3'd0) begin
                    memFire = 1'b1;
                    state_d = RESPOND;
                end else begin
                    latCnt_d = latCnt_q - 3'd1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            latCnt_q   <= '0;
            curPc_q    <= '0;
            curReg_q   <= '0;
            curData_q  <= '0;
            curStore_q <= 1'b0;
            curWord_q  <= '0;
        end else begin
            state_q  <= state_d;
            latCnt_q <= latCnt_d;
            if (popReq) begin
                curPc_q    <= headReq.pc;
                curReg_q   <= headReq.regTag;
                curData_q  <= headReq.data;
                curStore_q <= headReq.store;
                curWord_q  <= headReq.addr[WORD_W+1:2];
            end
        end
    end

    // Memory access and response registers; reset wins, so an in-flight access is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            ldValid_q <= 1'b0;
            ldPc_q    <= '0;
            ldReg_q   <= '0;
            ldData_q  <= '0;
            stDone_q  <= 1'b0;
            stData_q  <= '0;
            stPc_q    <= '0;
            addrErr_q <= 1'b0;
        end else begin
            ldValid_q <= 1'b0;
            stDone_q  <= 1'b0;
            addrErr_q <= popMisaligned;
            if (popForward) begin
                ldValid_q <= 1'b1;
                ldPc_q    <= headReq.pc;
                ldReg_q   <= headReq.regTag;
                ldData_q  <= headReq.data;
            end
            if (memFire) begin
                if (curStore_q == OP_STORE) begin
                    mem_q[curWord_q] <= curData_q;
                    stDone_q         <= 1'b1;
                    stData_q         <= curData_q;
                    stPc_q           <= curPc_q;
                end else begin
                    ldValid_q <= 1'b1;
                    ldPc_q    <= curPc_q;
                    ldReg_q   <= curReg_q;
                    ldData_q  <= mem_q[curWord_q];
                end
            end
        end
    end

    assign ld_valid = ldValid_q;
    assign ld_pc    = ldPc_q;
    assign ld_reg   = ldReg_q;
    assign ld_data  = ldData_q;
    assign st_done  = stDone_q;
    assign st_data  = stData_q;
    assign st_pc    = stPc_q;
    assign addr_err = addrErr_q;

endmodule
